// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display slice: blank pattern,
// active-low hex glyph table and a width helper for counter sizing.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} glyphs for 0-9, A, b, C, d, E, F
  localparam logic [6:0] GLYPHS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Minimum one bit so single-state counters still have a vector to live in
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/seg_hex_rom.sv
// Combinational nibble to active-low glyph lookup.
module seg_hex_rom
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = GLYPHS[nibble];

endmodule

// File: rtl/seg_hex_scan_display.sv
// Time-multiplexed hex driver for a common-anode seven-segment bank:
// captures a multi-nibble value and scans one digit per refresh period.
module seg_hex_scan_display
  import seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  lz_blank,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an,
  output logic                  scan_tick
);

  localparam int CW = clog2(REFRESH_DIV);
  localparam int IW = clog2(DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic                tick;
  logic                tick_q;
  logic [4*DIGITS-1:0] value_q;
  logic [DIGITS-1:0]   dp_q;
  logic                lz_q;
  logic [DIGITS-1:0]   blank;
  logic                upper_zero;
  logic [3:0]          nib;
  logic                dp_sel;
  logic                blank_sel;
  logic [6:0]          glyph;

  assign tick = enable && (cnt == CNT_MAX);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      idx    <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick;
      if (enable) begin
        if (tick) begin
          cnt <= '0;
          idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      value_q <= '0;
      dp_q    <= '0;
      lz_q    <= 1'b0;
    end else if (load) begin
      value_q <= value;
      dp_q    <= dp;
      lz_q    <= lz_blank;
    end
  end

  // Walk down from the top digit; a digit is a leading zero while every
  // nibble from it upward is zero. Digit 0 always stays visible.
  always_comb begin
    blank      = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (value_q[4*i +: 4] == 4'h0);
      blank[i]   = lz_q && upper_zero && (i != 0);
    end
  end

  always_comb begin
    nib       = '0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib       = value_q[4*i +: 4];
        dp_sel    = dp_q[i];
        blank_sel = blank[i];
      end
    end
  end

  seg_hex_rom u_rom (
    .nibble (nib),
    .glyph  (glyph)
  );

  // tick_q delays the pulse so it lines up with the cycle an changes digit
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      seg       <= SEG_OFF;
      dp_n      <= 1'b1;
      an        <= '1;
      scan_tick <= 1'b0;
    end else begin
      scan_tick <= tick_q;
      if (enable) begin
        seg  <= blank_sel ? SEG_OFF : glyph;
        dp_n <= ~dp_sel;
        an   <= ~(DIGITS'(1) << idx);
      end else begin
        seg  <= SEG_OFF;
        dp_n <= 1'b1;
        an   <= '1;
      end
    end
  end

endmodule

// File: tb/tb_seg_hex_scan_display.sv
// Self-checking bench for seg_hex_scan_display (DIGITS=4, REFRESH_DIV=4)
// against a cycle-count based behavioural model.
module tb_seg_hex_scan_display;

  localparam int D = 4;
  localparam int R = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        lz_blank;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;
  logic        scan_tick;

  int checks = 0;
  int errors = 0;

  logic [6:0]  glyph_tab [16];
  int          en_cycles;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic        m_lz;
  logic        m_prev_tick;
  logic [6:0]  e_seg;
  logic        e_dpn;
  logic [3:0]  e_an;
  logic        e_tick;

  always #5 clk = ~clk;

  seg_hex_scan_display #(.DIGITS(D), .REFRESH_DIV(R)) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .enable    (enable),
    .load      (load),
    .value     (value),
    .dp        (dp),
    .lz_blank  (lz_blank),
    .seg       (seg),
    .dp_n      (dp_n),
    .an        (an),
    .scan_tick (scan_tick)
  );

  task automatic checkOutput(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    en_cycles   = 0;
    m_val       = '0;
    m_dp        = '0;
    m_lz        = 1'b0;
    m_prev_tick = 1'b0;
  endtask

  // Digit on display is (enabled cycles so far / dwell) mod digit count
  task automatic predict();
    int d;
    logic [3:0] nv;
    d      = (en_cycles / R) % D;
    nv     = m_val[4*d +: 4];
    e_tick = m_prev_tick;
    if (!enable) begin
      e_seg = 7'h7F;
      e_dpn = 1'b1;
      e_an  = 4'hF;
    end else begin
      e_an    = 4'hF;
      e_an[d] = 1'b0;
      e_dpn   = !m_dp[d];
      if (m_lz && d > 0 && (m_val >> (4*d)) == 16'h0) e_seg = 7'h7F;
      else e_seg = glyph_tab[nv];
    end
  endtask

  task automatic applyStimulus();
    predict();
    @(posedge clk);
    #1;
    checkOutput("seg", seg, e_seg);
    checkOutput("dp_n", {6'b0, dp_n}, {6'b0, e_dpn});
    checkOutput("an", {3'b0, an}, {3'b0, e_an});
    checkOutput("scan_tick", {6'b0, scan_tick}, {6'b0, e_tick});
    m_prev_tick = enable && (en_cycles % R == R - 1);
    if (enable) en_cycles++;
    if (load) begin
      m_val = value;
      m_dp  = dp;
      m_lz  = lz_blank;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_seg"}, seg, 7'h7F);
    checkOutput({tag, "_dp_n"}, {6'b0, dp_n}, 7'h01);
    checkOutput({tag, "_an"}, {3'b0, an}, 7'h0F);
    checkOutput({tag, "_tick"}, {6'b0, scan_tick}, 7'h00);
  endtask

  task automatic runSteps(input int n);
    for (int k = 0; k < n; k++) applyStimulus();
  endtask

  initial begin
    glyph_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    reset    = 1'b0;
    enable   = 1'b1;
    load     = 1'b0;
    value    = '0;
    dp       = '0;
    lz_blank = 1'b0;
    resetModel();

    #1 reset = 1'b1;
    #2 checkResetValues("reset");
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    applyStimulus();
    checkOutput("first_seg", seg, 7'h40);
    checkOutput("first_an", {3'b0, an}, 7'h0E);
    runSteps(19);

    value = 16'h3A0F; dp = 4'b0010; lz_blank = 1'b0; load = 1'b1;
    applyStimulus();
    load = 1'b0;
    runSteps(20);

    value = 16'h0005; dp = 4'b0000; lz_blank = 1'b1; load = 1'b1;
    applyStimulus();
    load = 1'b0;
    runSteps(20);

    value = 16'h0000; load = 1'b1;
    applyStimulus();
    load = 1'b0;
    runSteps(20);

    value = 16'h1234; dp = 4'b1001; lz_blank = 1'b0; load = 1'b1;
    applyStimulus();
    load = 1'b0;
    for (int k = 0; k < 20 && !(((en_cycles / R) % D) == 2 && (en_cycles % R) == 1); k++)
      applyStimulus();
    enable = 1'b0;
    runSteps(10);
    enable = 1'b1;
    runSteps(12);

    for (int k = 0; k < 20 && (en_cycles % (R * D)) != 7; k++) applyStimulus();
    value = 16'hBEEF; dp = 4'b0100; load = 1'b1;
    applyStimulus();
    load = 1'b0;
    runSteps(8);

    for (int k = 0; k < 300; k++) begin
      enable   = ($urandom_range(99) < 85);
      load     = ($urandom_range(99) < 10);
      value    = 16'($urandom);
      if ($urandom_range(1) == 1) value = value >> (4 * $urandom_range(3));
      dp       = 4'($urandom);
      lz_blank = 1'($urandom);
      applyStimulus();
    end
    enable = 1'b1;
    load   = 1'b0;

    value = 16'h00C7; lz_blank = 1'b1; dp = 4'b1111; load = 1'b1;
    applyStimulus();
    load = 1'b0;
    runSteps(6);
    #2 reset = 1'b1;
    #1 checkResetValues("async");
    #2 reset = 1'b0;
    resetModel();
    runSteps(18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_hex_scan_display.md
# seg_hex_scan_display

Time-multiplexed hex display driver for a multi-digit common-anode seven-segment bank. It captures a DIGITS-nibble value on a load strobe and scans one digit per refresh period. Each digit gets a hex glyph (0-9, A, b, C, d, E, F), a per-digit decimal point and optional leading-zero suppression. It sits between datapath registers and the board display pins, replacing one static decoder per digit.

## Interface
- DIGITS, 4: number of digits scanned; 1..8.
- REFRESH_DIV, 50000: clock cycles each digit stays on; ≥1.
- CLOCK_50  in  1: system clock; all state on rising edge.
- reset  in  1: asynchronous, active-high reset.
- enable  in  1: 1 = scan; 0 = hold scan state, display dark.
- load  in  1: capture value/dp/lz_blank this cycle.
- value  in  4*DIGITS: hex nibbles; nibble i = value[4i+3:4i]; digit 0 least significant.
- dp  in  DIGITS: decimal point request per digit, 1 = lit.
- lz_blank  in  1: 1 = suppress leading zeros.
- seg  out  7: segments {g,f,e,d,c,b,a}, active-low.
- dp_n  out  1: decimal point, active-low.
- an  out  DIGITS: digit enables, active-low, one-hot-low while scanning.
- scan_tick  out  1: one-cycle pulse when scan index advances.

## Operation
- Capture registers (value_q, dp_q, lz_q) load on load=1; reset to 0. Holding load=1 recaptures every cycle.
- Prescaler counts 0..REFRESH_DIV-1; wraps to 0. The tick is count==REFRESH_DIV-1 with enable=1.
- Scan index idx advances on tick and wraps DIGITS-1 -> 0. Reset idx=0, prescaler=0.
- enable=0 freezes prescaler and idx. Next cycle it drives an all 1, seg 7'h7F, dp_n 1.
- Glyphs (active-low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Leading-zero suppression: if lz_q=1, digit i>0 is suppressed when nibbles i..DIGITS-1 are all zero. Digit 0 is never suppressed.
- A suppressed digit drives seg 7'h7F. Its an bit still asserts, and dp_n still follows dp_q[i].
- Driven digit: an[idx]=0, all other an bits 1; seg = glyph(value_q nibble idx) or blank; dp_n = ~dp_q[idx].
- Reset mid-scan: all outputs go to reset values immediately (asynchronous); capture is lost.

## Timing
- Reset values: seg 7'h7F, dp_n 1, an all 1, scan_tick 0.
- seg, dp_n, an and scan_tick are registered from current idx and capture registers: 1-cycle latency.
- First cycle after reset release with enable=1: registers update to digit 0 showing value 0. lz_blank defaults 0, so the glyph is "0".
- load at cycle t: outputs reflect the new value at t+2 (capture, then output register).
- load and tick in the same cycle: the new idx and new capture are used together, with no mixed frame.
- Digit dwell = REFRESH_DIV cycles; frame = DIGITS*REFRESH_DIV cycles.
- REFRESH_DIV=1: idx advances every enabled cycle.
- scan_tick is registered: high the cycle an moves to the next digit.
- DIGITS=1: idx stays 0; scan_tick still pulses every REFRESH_DIV cycles.

## Structure
- Shared package seg_pkg:
  - SEG_OFF = 7'h7F
  - 16-entry glyph constant array
  - width function clog2 for idx/prescaler sizing
- Sub-module seg_hex_rom: combinational nibble -> active-low glyph from seg_pkg. It is instantiated once on the selected nibble, not per digit.
- Top: prescaler, idx counter, capture regs, leading-zero mask (combinational over value_q), output regs.

## Test plan
All scenarios use DIGITS=4, REFRESH_DIV=4.
- Reset release with enable=1, no load -> an=1110, seg=1000000 the cycle after release; scan_tick every 4 cycles; an sequence 1110, 1101, 1011, 0111, 1110.
- load value=16'h3A0F, dp=4'b0010, lz_blank=0 -> over one frame:
  - digit 0: seg=0001110 (F)
  - digit 1: seg=1000000, dp_n=0
  - digit 2: seg=0001000 (A)
  - digit 3: seg=0110000 (3)
- load value=16'h0005, lz_blank=1 -> digit 0 seg=0010010; digits 1-3 seg=7F with an still stepping. value=16'h0000 with lz_blank=1 -> digit 0 shows "0".
- enable=0 mid-digit 2 for 10 cycles -> an=1111, seg=7F. On re-enable, digit 2 resumes with the prescaler count preserved, and the tick comes at the remaining count.
- load asserted on the same cycle as tick 1->2 -> digit 2 shows the new nibble at once; no frame mixes old and new.
- Async reset pulse mid-frame, not clock-aligned -> outputs go to reset values before the next edge; capture reads 0 afterward.
